// File: rtl/clock_divider.sv
// Registered divide-by-DIVISOR clock with 50% duty cycle.
// Optional tick strobe enabled by CLOCK_DIVIDER_TICK_EN.
module clock_divider #(
  parameter int DIVISOR = 2
) (
  input  logic clk_in,
  input  logic rst,
`ifdef CLOCK_DIVIDER_TICK_EN
  output logic tick,
`endif
  output logic clk_out
);

  localparam int HALF = DIVISOR / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] TERM = CW'(HALF - 1);

  if (DIVISOR < 2 || (DIVISOR % 2) != 0) begin : g_bad_divisor
    $error("clock_divider: DIVISOR must be even and >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_q, clk_d;
  logic          wrap;

  assign wrap = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    clk_d = clk_q;
    if (wrap) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk_out = clk_q;

`ifdef CLOCK_DIVIDER_TICK_EN
  logic tick_q;

  // Set on the same edge clk_out rises, so it covers the following cycle.
  always_ff @(posedge clk_in) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= wrap & ~clk_q;
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider at DIVISOR = 2, 4 and 16.
// Tick checks on the DIVISOR=4 instance when CLOCK_DIVIDER_TICK_EN is set.
module tb_clock_divider;

  logic clk = 1'b0;
  logic rst;
  logic out2, out4, out16;
`ifdef CLOCK_DIVIDER_TICK_EN
  logic tick4;
`endif

  int errors = 0;
  int checks = 0;
  int n = 0;

  always #5 clk = ~clk;

  clock_divider #(.DIVISOR(2)) u_d2 (
    .clk_in (clk),
    .rst    (rst),
`ifdef CLOCK_DIVIDER_TICK_EN
    .tick   (),
`endif
    .clk_out(out2)
  );

  clock_divider #(.DIVISOR(4)) u_d4 (
    .clk_in (clk),
    .rst    (rst),
`ifdef CLOCK_DIVIDER_TICK_EN
    .tick   (tick4),
`endif
    .clk_out(out4)
  );

  clock_divider #(.DIVISOR(16)) u_d16 (
    .clk_in (clk),
    .rst    (rst),
`ifdef CLOCK_DIVIDER_TICK_EN
    .tick   (),
`endif
    .clk_out(out16)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  // n counts rising edges seen with rst low since the last release.
  // With half-period H, clk_out = (n / H) odd; it rises when n % 2H == H.
  task automatic check_sample();
    chk("d2_clk_out", out2, 1'((n / 1) % 2));
    chk("d4_clk_out", out4, 1'((n / 2) % 2));
    chk("d16_clk_out", out16, 1'((n / 8) % 2));
`ifdef CLOCK_DIVIDER_TICK_EN
    chk("d4_tick", tick4, 1'(n % 4 == 2));
`endif
  endtask

  task automatic run(input int samples);
    for (int i = 0; i < samples; i++) begin
      check_sample();
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_d2"}, out2, 1'b0);
    chk({tag, "_d4"}, out4, 1'b0);
    chk({tag, "_d16"}, out16, 1'b0);
`ifdef CLOCK_DIVIDER_TICK_EN
    chk({tag, "_tick"}, tick4, 1'b0);
`endif
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    check_reset("reset1");
    rst = 1'b0;
    n = 0;
    // Ten periods of the slowest divider, every sample checked.
    run(160);
    // Advance into the d16 high phase until three high samples seen.
    run(16 + 11);
    chk("d16_high_before_rst", out16, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("reset_mid");
    @(negedge clk);
    check_reset("reset_hold");
    rst = 1'b0;
    n = 0;
    // Full low half-period after release, then the high half.
    run(8);
    chk("d16_first_high", out16, 1'b1);
    run(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
